// File: rtl/writeback_bus_arbiter.sv
// Per-source result FIFOs drained onto three shared writeback buses by a rotating-priority selector.
// Dispatch stalls on almost_full; overflow is a sticky flag for a push that found its FIFO full.
module writeback_bus_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_SRC-1:0]      src_en,
    input  logic [5*NUM_SRC-1:0]    src_vregid,
    input  logic [32*NUM_SRC-1:0]   src_val,
    output logic                    wb1_en,
    output logic [4:0]              wb1_vregid,
    output logic [31:0]             wb1_val,
    output logic                    wb2_en,
    output logic [4:0]              wb2_vregid,
    output logic [31:0]             wb2_val,
    output logic                    wb3_en,
    output logic [4:0]              wb3_vregid,
    output logic [31:0]             wb3_val,
    output logic [NUM_SRC-1:0]      almost_full,
    output logic                    overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);
    localparam logic [SW:0]   NSRC_EXT = (SW + 1)'(NUM_SRC);

    typedef struct packed {
        logic [4:0]  vregid;
        logic [31:0] val;
    } entry_t;

    entry_t         r_mem     [NUM_SRC][DEPTH];
    logic [PW-1:0]  r_wr_ptr  [NUM_SRC];
    logic [PW-1:0]  r_rd_ptr  [NUM_SRC];
    logic [CW-1:0]  r_count   [NUM_SRC];
    logic [SW-1:0]  r_rr_ptr;
    logic [2:0]     r_wb_en;
    entry_t         r_wb      [3];
    logic           r_overflow;

    logic [NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_drop;
    logic [2:0]         w_bus_vld;
    logic [SW-1:0]      w_bus_src [3];
    logic [SW-1:0]      w_rr_next;
    logic [SW:0]        w_idx;
    logic [1:0]         w_nbus;

    // Rotating scan from r_rr_ptr; the first three non-empty FIFOs take buses 1..3 in scan order.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_grant   = '0;
        w_bus_vld = '0;
        for (int b = 0; b < 3; b++) w_bus_src[b] = '0;
        w_rr_next = r_rr_ptr;
        w_nbus    = 2'd0;
        w_idx     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (SW + 1)'(k);
            if (w_idx >= NSRC_EXT) w_idx = w_idx - NSRC_EXT;
            if (r_count[w_idx[SW-1:0]] != '0 && w_nbus != 2'd3) begin
                w_grant[w_idx[SW-1:0]] = 1'b1;
                w_bus_vld[w_nbus]      = 1'b1;
                w_bus_src[w_nbus]      = w_idx[SW-1:0];
                w_nbus                 = w_nbus + 2'd1;
                w_rr_next = (w_idx[SW-1:0] == SW'(NUM_SRC - 1)) ? '0 : SW'(w_idx[SW-1:0] + SW'(1));
            end
        end
    end

    // A full FIFO still accepts a push when its head is popped on the same edge.
    always_comb begin
        w_push      = '0;
        w_drop      = '0;
        almost_full = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_push[i]      = src_en[i] && (r_count[i] != FULL_CNT || w_grant[i]);
            w_drop[i]      = src_en[i] && !w_push[i];
            almost_full[i] = (r_count[i] >= AF_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            for (int b = 0; b < 3; b++) r_wb[b] <= '0;
            r_rr_ptr   <= '0;
            r_wb_en    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr <= '0;
            r_wb_en  <= '0;
        end else begin
            r_rr_ptr   <= w_rr_next;
            r_wb_en    <= w_bus_vld;
            r_overflow <= r_overflow | (|w_drop);
            for (int b = 0; b < 3; b++) begin
                if (w_bus_vld[b]) r_wb[b] <= r_mem[w_bus_src[b]][r_rd_ptr[w_bus_src[b]]];
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_push[i])  r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_grant[i]) r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                case ({w_push[i], w_grant[i]})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // NOTE: FIFO storage carries no reset; counts and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= {src_vregid[5*i +: 5], src_val[32*i +: 32]};
            end
        end
    end

    assign wb1_en     = r_wb_en[0];
    assign wb1_vregid = r_wb[0].vregid;
    assign wb1_val    = r_wb[0].val;
    assign wb2_en     = r_wb_en[1];
    assign wb2_vregid = r_wb[1].vregid;
    assign wb2_val    = r_wb[1].val;
    assign wb3_en     = r_wb_en[2];
    assign wb3_vregid = r_wb[2].vregid;
    assign wb3_val    = r_wb[2].val;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_writeback_bus_arbiter.sv
// Directed bench for writeback_bus_arbiter: single result, rotation order, long all-source stream
// with wrap/full/overflow, flush and reset.
module tb_writeback_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   src_en;
    logic [19:0]  src_vregid;
    logic [127:0] src_val;
    logic         wb1_en, wb2_en, wb3_en;
    logic [4:0]   wb1_vregid, wb2_vregid, wb3_vregid;
    logic [31:0]  wb1_val, wb2_val, wb3_val;
    logic [3:0]   almost_full;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    writeback_bus_arbiter #(.NUM_SRC(4), .DEPTH(4), .AF_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_en(src_en), .src_vregid(src_vregid), .src_val(src_val),
        .wb1_en(wb1_en), .wb1_vregid(wb1_vregid), .wb1_val(wb1_val),
        .wb2_en(wb2_en), .wb2_vregid(wb2_vregid), .wb2_val(wb2_val),
        .wb3_en(wb3_en), .wb3_vregid(wb3_vregid), .wb3_val(wb3_val),
        .almost_full(almost_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] vr, input logic [31:0] v);
        src_en[i]           = 1'b1;
        src_vregid[5*i +: 5] = vr;
        src_val[32*i +: 32]  = v;
    endtask

    task automatic check_bus(input string tag, input int b, input logic en,
                             input logic [4:0] vr, input logic [31:0] v);
        logic        e;
        logic [4:0]  r;
        logic [31:0] x;
        case (b)
            0:       begin e = wb1_en; r = wb1_vregid; x = wb1_val; end
            1:       begin e = wb2_en; r = wb2_vregid; x = wb2_val; end
            default: begin e = wb3_en; r = wb3_vregid; x = wb3_val; end
        endcase
        check($sformatf("%s_wb%0d_en", tag, b + 1), e, en);
        if (en) begin
            check($sformatf("%s_wb%0d_vregid", tag, b + 1), r, vr);
            check($sformatf("%s_wb%0d_val", tag, b + 1), x, v);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int b = 0; b < 3; b++) check_bus(tag, b, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_zero_fields(input string tag);
        check({tag, "_wb1_vregid"}, wb1_vregid, 0);
        check({tag, "_wb1_val"}, wb1_val, 0);
        check({tag, "_wb2_vregid"}, wb2_vregid, 0);
        check({tag, "_wb2_val"}, wb2_val, 0);
        check({tag, "_wb3_vregid"}, wb3_vregid, 0);
        check({tag, "_wb3_val"}, wb3_val, 0);
    endtask

    // Stream entry j of source s.
    function automatic logic [4:0] ent_vr(input int s, input int j);
        return 5'(s * 8 + j);
    endfunction

    function automatic logic [31:0] ent_val(input int s, input int j);
        return 32'hC0DE_0000 | 32'(s << 8) | 32'(j);
    endfunction

    // almost_full after stream edge c+1, from hand-traced counts (bit i = source i has >= 2 entries).
    logic [3:0] af_tbl [20] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b0000};

    initial begin
        int k;
        rst        = 1'b0;
        flush      = 1'b0;
        src_en     = '0;
        src_vregid = '0;
        src_val    = '0;
        step();
        step();
        check_idle("reset");
        check_zero_fields("reset");
        check("reset_af", almost_full, 4'b0000);
        check("reset_ovf", overflow, 1'b0);
        rst = 1'b1;

        // Single result from source 1: visible on wb1 one edge after the push edge.
        set_src(1, 5'd7, 32'hDEAD_BEEF);
        step();
        src_en = '0;
        check_idle("single_early");
        step();
        check_bus("single", 0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        check_bus("single", 1, 1'b0, 5'd0, 32'd0);
        check_bus("single", 2, 1'b0, 5'd0, 32'd0);
        step();
        check_idle("single_once");

        // rr_ptr is now 2: order must be 2,3,0 then 1.
        for (int i = 0; i < 4; i++) set_src(i, 5'(10 + i), 32'h100 + 32'(i));
        step();
        src_en = '0;
        step();
        check_bus("rr2", 0, 1'b1, 5'd12, 32'h102);
        check_bus("rr2", 1, 1'b1, 5'd13, 32'h103);
        check_bus("rr2", 2, 1'b1, 5'd10, 32'h100);
        step();
        check_bus("rr2_tail", 0, 1'b1, 5'd11, 32'h101);
        check_bus("rr2_tail", 1, 1'b0, 5'd0, 32'd0);
        check_bus("rr2_tail", 2, 1'b0, 5'd0, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_idle("flush_rr");

        // Four simultaneous pushes from rr_ptr=0.
        for (int i = 0; i < 4; i++) set_src(i, 5'(1 + i), 32'hA0 + 32'(i));
        step();
        src_en = '0;
        step();
        check_bus("quad", 0, 1'b1, 5'd1, 32'hA0);
        check_bus("quad", 1, 1'b1, 5'd2, 32'hA1);
        check_bus("quad", 2, 1'b1, 5'd3, 32'hA2);
        step();
        check_bus("quad_tail", 0, 1'b1, 5'd4, 32'hA3);
        check_bus("quad_tail", 1, 1'b0, 5'd0, 32'd0);
        check_bus("quad_tail", 2, 1'b0, 5'd0, 32'd0);
        step();
        check_idle("quad_done");

        // All four sources push for 14 cycles. Grants rotate strictly, so the k-th result
        // overall is entry k/4 of source k%4. Source 3's entry 13 hits a full, un-popped FIFO
        // and is dropped, so only 55 results come out.
        for (int c = 0; c < 20; c++) begin
            if (c < 14) begin
                for (int s = 0; s < 4; s++) set_src(s, ent_vr(s, c), ent_val(s, c));
            end else begin
                src_en = '0;
            end
            step();
            check($sformatf("stream_af_c%0d", c), almost_full, af_tbl[c]);
            check($sformatf("stream_ovf_c%0d", c), overflow, (c >= 13) ? 1'b1 : 1'b0);
            if (c >= 1) begin
                for (int b = 0; b < 3; b++) begin
                    k = 3 * (c - 1) + b;
                    if (k < 55)
                        check_bus($sformatf("stream_d%0d", c - 1), b, 1'b1, ent_vr(k % 4, k / 4), ent_val(k % 4, k / 4));
                    else
                        check_bus($sformatf("stream_d%0d", c - 1), b, 1'b0, 5'd0, 32'd0);
                end
            end
        end
        step();
        check_idle("stream_done");

        // Flush with entries buffered; rr_ptr is 3 here so the first drain is 3,0,1.
        for (int i = 0; i < 4; i++) set_src(i, 5'(16 + i), 32'hF000_0000 + 32'(i));
        step();
        for (int i = 0; i < 4; i++) set_src(i, 5'(20 + i), 32'hF000_0010 + 32'(i));
        step();
        src_en = '0;
        check_bus("preflush", 0, 1'b1, 5'd19, 32'hF000_0003);
        check_bus("preflush", 1, 1'b1, 5'd16, 32'hF000_0000);
        check_bus("preflush", 2, 1'b1, 5'd17, 32'hF000_0001);
        check("preflush_af", almost_full, 4'b0100);
        flush = 1'b1;
        set_src(0, 5'd31, 32'hBAD0_0000);
        step();
        flush  = 1'b0;
        src_en = '0;
        check_idle("flush");
        check("flush_af", almost_full, 4'b0000);
        check("flush_ovf", overflow, 1'b1);
        step();
        check_idle("flush_empty");

        // After flush rr_ptr=0 and only the new entries drain.
        for (int i = 0; i < 4; i++) set_src(i, 5'(24 + i), 32'hE000_0000 + 32'(i));
        step();
        src_en = '0;
        step();
        check_bus("postflush", 0, 1'b1, 5'd24, 32'hE000_0000);
        check_bus("postflush", 1, 1'b1, 5'd25, 32'hE000_0001);
        check_bus("postflush", 2, 1'b1, 5'd26, 32'hE000_0002);
        step();
        check_bus("postflush_tail", 0, 1'b1, 5'd27, 32'hE000_0003);
        check_bus("postflush_tail", 1, 1'b0, 5'd0, 32'd0);
        check_bus("postflush_tail", 2, 1'b0, 5'd0, 32'd0);
        step();
        check_idle("postflush_done");

        // Reset clears overflow and every bus field.
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_idle("rst2");
        check_zero_fields("rst2");
        check("rst2_af", almost_full, 4'b0000);
        check("rst2_ovf", overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
